vfifo_sc_fwft_fifo: RTL

Single-clock, first-word-fall-through FIFO built around an internal simple dual-port RAM. The RAM has one write port and one read port with a registered read address. The block adds pointer and level management, programmable almost-full and almost-empty flags, sticky error flags and a synchronous flush. It is the generic buffering primitive for the versatile_fifo family: it sits between a producer and a consumer in the same clock domain and replaces ad-hoc RAM-plus-counter glue.

---
 rtl/vfifo_sc_fwft_fifo_if.sv | 28 ++
 rtl/vfifo_sc_fwft_fifo.sv | 95 +++++++++
 2 files changed

// File: rtl/vfifo_sc_fwft_fifo_if.sv
// Producer/consumer bundle for the single-clock FWFT FIFO.
// master = the side driving data and requests; slave = the FIFO.
interface vfifo_sc_fwft_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] d;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] q;
  logic                  rd_en;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output d, wr_en, rd_en,
    input  full, almost_full, q, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  d, wr_en, rd_en,
    output full, almost_full, q, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/vfifo_sc_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO over a simple dual-port RAM with a
// registered read address, level flags, sticky error flags and synchronous flush.
module vfifo_sc_fwft_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = 254,
  parameter int unsigned AE_LEVEL   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  vfifo_sc_fwft_fifo_if.slave  bus
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OneCnt   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AfCnt    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeCnt    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  // Registered RAM read address; always equals the head pointer.
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, pop_acc;

  assign wr_acc  = bus.wr_en & ~full_q & ~clear;
  assign pop_acc = bus.rd_en & ~empty_q & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.wr_en & full_q);
    unf_d    = unf_q | (bus.rd_en & empty_q);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, pop_acc})
        2'b10:   count_d = count_q + OneCnt;
        2'b01:   count_d = count_q - OneCnt;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DepthCnt);
    // A head word written on this edge is not yet visible through the read port.
    empty_d = (count_d == '0) || (wr_acc && count_d == OneCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.d;
  end

  assign bus.q            = mem[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
